// File: rtl/arith_dec_pkg.sv
// arith_dec_pkg: shared types and constants for the arithmetic_decoder slice.
//   dec_state_e   : decoder FSM states (initial fill, idle, symbol search, refill)
//   EC_PROB_SHIFT : probability / icdf down-shift before the range multiply
//   EC_MIN_PROB   : minimum per-symbol probability offset
//   DIF_INIT      : dif window reset value, 2^(W-1)-1 for W = 32
//   CNT_INIT      : bit-count reset value
package arith_dec_pkg;

  typedef enum logic [1:0] {
    StInitFill,
    StIdle,
    StSearch,
    StRefill
  } dec_state_e;

  localparam int unsigned EC_PROB_SHIFT = 6;
  localparam int unsigned EC_MIN_PROB   = 4;
  localparam logic [31:0] DIF_INIT      = 32'h7FFF_FFFF;
  localparam int          CNT_INIT      = -15;

endpackage

// File: rtl/arithmetic_decoder_if.sv
// arithmetic_decoder_if: handshake bundle between the decoder and its neighbours.
//   in_*    : bitstream byte source (in_last marks the final byte)
//   req_*   : symbol request from the syntax logic (alphabet size, boolean mode, probability)
//   icdf*   : inverse-CDF entry stream, entry 0 first
//   sym*    : decoded symbol with one-cycle strobe
// Modports: master = requester/byte-source side, slave = decoder side.
interface arithmetic_decoder_if #(
  parameter int unsigned RANGE_WIDTH  = 16,
  parameter int unsigned SYMBOL_WIDTH = 4
);

  logic [7:0]              in_byte;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    req_valid;
  logic                    req_ready;
  logic [SYMBOL_WIDTH:0]   req_nsyms;
  logic                    req_bool;
  logic [RANGE_WIDTH-1:0]  req_f;
  logic [15:0]             icdf;
  logic                    icdf_valid;
  logic                    icdf_ready;
  logic [SYMBOL_WIDTH-1:0] sym;
  logic                    sym_valid;

  modport master (
    output in_byte, in_valid, in_last, req_valid, req_nsyms, req_bool, req_f, icdf, icdf_valid,
    input  in_ready, req_ready, icdf_ready, sym, sym_valid
  );

  modport slave (
    input  in_byte, in_valid, in_last, req_valid, req_nsyms, req_bool, req_f, icdf, icdf_valid,
    output in_ready, req_ready, icdf_ready, sym, sym_valid
  );

endinterface

// File: rtl/arith_dec_normalize.sv
// arith_dec_normalize: combinational range renormalization after a decision.
//   i_r   : new (unnormalized) range, never zero
//   i_dif : dif window after the decision subtraction
//   i_cnt : bit count before renormalization
//   o_rng : i_r shifted so its msb sits at bit RANGE_WIDTH-1
//   o_dif : ((i_dif + 1) << d) - 1, i.e. ones shifted in from the bottom
//   o_cnt : i_cnt - d
module arith_dec_normalize #(
  parameter int unsigned RANGE_WIDTH = 16,
  parameter int unsigned DIF_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic [RANGE_WIDTH-1:0]      i_r,
  input  logic [DIF_WIDTH-1:0]        i_dif,
  input  logic signed [CNT_WIDTH-1:0] i_cnt,
  output logic [RANGE_WIDTH-1:0]      o_rng,
  output logic [DIF_WIDTH-1:0]        o_dif,
  output logic signed [CNT_WIDTH-1:0] o_cnt
);

  localparam int unsigned DW = $clog2(RANGE_WIDTH);

  logic [DW-1:0]        w_d;
  logic [DIF_WIDTH-1:0] w_dif_inc;

  // Leading-zero count; the highest set bit wins because it is visited last.
  always_comb begin
    w_d = DW'(RANGE_WIDTH - 1);
    for (int i = 0; i < int'(RANGE_WIDTH); i++) begin
      if (i_r[i]) begin
        w_d = DW'(int'(RANGE_WIDTH) - 1 - i);
      end
    end
  end

  assign w_dif_inc = i_dif + DIF_WIDTH'(1);
  assign o_rng     = i_r << w_d;
  assign o_dif     = (w_dif_inc << w_d) - DIF_WIDTH'(1);
  assign o_cnt     = i_cnt - CNT_WIDTH'(w_d);

endmodule

// File: rtl/arithmetic_decoder.sv
// arithmetic_decoder: AV1-compatible multi-symbol range decoder (Q15 dif/rng/cnt state).
//   general_clk : clock
//   reset       : synchronous active-high reset, restarts the initial fill
//   bus         : arithmetic_decoder_if.slave (byte input, request, icdf stream, symbol out)
//   RNG_OUTPUT  : current rng (debug)
//   DIF_OUTPUT  : current dif window (debug)
//   CNT_OUTPUT  : current signed bit count (debug)
// Optional feature macro ARITH_DEC_BOOL_EN: single-cycle boolean decode from req_f when
// req_bool is set. Without it req_bool/req_f are ignored and every request is multi-symbol.
module arithmetic_decoder
  import arith_dec_pkg::*;
#(
  parameter int unsigned RANGE_WIDTH  = 16,
  parameter int unsigned DIF_WIDTH    = 32,
  parameter int unsigned SYMBOL_WIDTH = 4,
  parameter int unsigned CNT_WIDTH    = 6
) (
  input  logic                   general_clk,
  input  logic                   reset,
  arithmetic_decoder_if.slave    bus,
  output logic [RANGE_WIDTH-1:0] RNG_OUTPUT,
  output logic [DIF_WIDTH-1:0]   DIF_OUTPUT,
  output logic [CNT_WIDTH-1:0]   CNT_OUTPUT
);

  localparam int unsigned ProbW = 16 - EC_PROB_SHIFT;
  localparam int unsigned ProdW = (RANGE_WIDTH - 8) + ProbW;
  localparam logic signed [CNT_WIDTH-1:0] CntFillDone = CNT_WIDTH'(DIF_WIDTH - 24);
  localparam logic [RANGE_WIDTH-1:0] RngInit = {1'b1, {(RANGE_WIDTH - 1){1'b0}}};

  dec_state_e                   r_state, w_state_d;
  logic [RANGE_WIDTH-1:0]       r_rng, w_rng_d;
  logic [DIF_WIDTH-1:0]         r_dif, w_dif_d;
  logic signed [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
  logic                         r_eos, w_eos_d;
  logic [SYMBOL_WIDTH-1:0]      r_sym, w_sym_d;
  logic                         r_sym_valid, w_sym_valid_d;
  logic [SYMBOL_WIDTH-1:0]      r_ret, w_ret_d;
  logic [SYMBOL_WIDTH-1:0]      r_n, w_n_d;
  logic [RANGE_WIDTH-1:0]       r_u, w_u_d;

  logic                         w_is_bool;
  logic [ProbW-1:0]             w_prob;
  logic [ProdW-1:0]             w_prod;
  logic [RANGE_WIDTH-1:0]       w_min_term;
  logic [RANGE_WIDTH-1:0]       w_v;
  logic [15:0]                  w_c;
  logic                         w_ge;
  logic                         w_take_lower;
  logic                         w_req_hs;
  logic                         w_icdf_hs;
  logic                         w_decide;
  logic [SYMBOL_WIDTH-1:0]      w_dec_sym;
  logic [RANGE_WIDTH-1:0]       w_r;
  logic [DIF_WIDTH-1:0]         w_dif_sub;
  logic [RANGE_WIDTH-1:0]       w_norm_rng;
  logic [DIF_WIDTH-1:0]         w_norm_dif;
  logic signed [CNT_WIDTH-1:0]  w_norm_cnt;
  logic                         w_fill_state;
  logic                         w_fill_step;
  logic [7:0]                   w_fill_byte;
  logic [CNT_WIDTH-1:0]         w_fill_shift;
  logic [DIF_WIDTH-1:0]         w_fill_dif;
  logic signed [CNT_WIDTH-1:0]  w_fill_cnt;
  logic                         w_unused_icdf_lsbs;

  assign w_req_hs  = (r_state == StIdle) && bus.req_valid;
  assign w_icdf_hs = bus.icdf_ready && bus.icdf_valid;
  assign w_unused_icdf_lsbs = ^bus.icdf[EC_PROB_SHIFT-1:0];

`ifdef ARITH_DEC_BOOL_EN
  logic                   r_is_bool;
  logic [RANGE_WIDTH-1:0] r_f;
  logic                   w_unused_f_lsbs;

  always_ff @(posedge general_clk) begin
    if (reset) begin
      r_is_bool <= 1'b0;
      r_f       <= '0;
    end else if (w_req_hs) begin
      r_is_bool <= bus.req_bool;
      r_f       <= bus.req_f;
    end
  end

  assign w_is_bool       = r_is_bool;
  assign w_prob          = r_is_bool ? r_f[RANGE_WIDTH-1:EC_PROB_SHIFT]
                                     : bus.icdf[15:EC_PROB_SHIFT];
  assign w_unused_f_lsbs = ^r_f[EC_PROB_SHIFT-1:0];
`else
  logic w_unused_bool;

  assign w_unused_bool = ^{bus.req_bool, bus.req_f};
  assign w_is_bool     = 1'b0;
  assign w_prob        = bus.icdf[15:EC_PROB_SHIFT];
`endif

  // v = ((rng >> 8) * (p >> 6) >> 1) + min-prob term; shared by both decode modes.
  assign w_prod     = ProdW'(r_rng[RANGE_WIDTH-1:8]) * ProdW'(w_prob);
  assign w_min_term = w_is_bool ? RANGE_WIDTH'(EC_MIN_PROB)
                                : RANGE_WIDTH'(EC_MIN_PROB) * RANGE_WIDTH'(r_n - r_ret);
  assign w_v        = RANGE_WIDTH'(w_prod >> 1) + w_min_term;

  // Comparing the top 16 dif bits with v equals comparing dif with v << (W-16).
  assign w_c  = r_dif[DIF_WIDTH-1 -: 16];
  assign w_ge = (w_c >= w_v);

  // Multi-symbol always keeps the interval below u_prev; boolean keeps it only for sym 0.
  assign w_take_lower = !w_is_bool || w_ge;
  assign w_r          = w_take_lower ? (r_u - w_v) : w_v;
  assign w_dif_sub    = w_take_lower ? (r_dif - {w_v, {(DIF_WIDTH - 16){1'b0}}}) : r_dif;
  assign w_dec_sym    = w_is_bool ? SYMBOL_WIDTH'(!w_ge) : r_ret;
  assign w_decide     = w_is_bool || (w_icdf_hs && (w_ge || (r_ret == r_n)));

  arith_dec_normalize #(
    .RANGE_WIDTH(RANGE_WIDTH),
    .DIF_WIDTH  (DIF_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_normalize (
    .i_r  (w_r),
    .i_dif(w_dif_sub),
    .i_cnt(r_cnt),
    .o_rng(w_norm_rng),
    .o_dif(w_norm_dif),
    .o_cnt(w_norm_cnt)
  );

  // After end of stream the fill keeps stepping once per cycle with zero bytes.
  assign w_fill_state = (r_state == StInitFill) || (r_state == StRefill);
  assign w_fill_step  = w_fill_state && (r_eos || bus.in_valid);
  assign w_fill_byte  = r_eos ? 8'h00 : bus.in_byte;
  assign w_fill_shift = $unsigned(CntFillDone - r_cnt);
  assign w_fill_dif   = r_dif ^ (DIF_WIDTH'(w_fill_byte) << w_fill_shift);
  assign w_fill_cnt   = r_cnt + CNT_WIDTH'(8);

  always_comb begin
    w_state_d     = r_state;
    w_rng_d       = r_rng;
    w_dif_d       = r_dif;
    w_cnt_d       = r_cnt;
    w_eos_d       = r_eos;
    w_sym_d       = r_sym;
    w_sym_valid_d = 1'b0;
    w_ret_d       = r_ret;
    w_n_d         = r_n;
    w_u_d         = r_u;
    case (r_state)
      StInitFill, StRefill: begin
        if (w_fill_step) begin
          w_dif_d = w_fill_dif;
          w_cnt_d = w_fill_cnt;
          if (!r_eos && bus.in_last) begin
            w_eos_d = 1'b1;
          end
          if (w_fill_cnt > CntFillDone) begin
            w_state_d = StIdle;
          end
        end
      end
      StIdle: begin
        if (bus.req_valid) begin
          w_state_d = StSearch;
          w_ret_d   = '0;
          w_n_d     = SYMBOL_WIDTH'(bus.req_nsyms - 1'b1);
          w_u_d     = r_rng;
        end
      end
      StSearch: begin
        if (w_decide) begin
          w_sym_d       = w_dec_sym;
          w_sym_valid_d = 1'b1;
          w_rng_d       = w_norm_rng;
          w_dif_d       = w_norm_dif;
          w_cnt_d       = w_norm_cnt;
          w_state_d     = w_norm_cnt[CNT_WIDTH-1] ? StRefill : StIdle;
        end else if (w_icdf_hs) begin
          w_u_d   = w_v;
          w_ret_d = r_ret + 1'b1;
        end
      end
      default: w_state_d = StInitFill;
    endcase
  end

  always_ff @(posedge general_clk) begin
    if (reset) begin
      r_state     <= StInitFill;
      r_rng       <= RngInit;
      r_dif       <= DIF_WIDTH'(DIF_INIT);
      r_cnt       <= CNT_WIDTH'(CNT_INIT);
      r_eos       <= 1'b0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_ret       <= '0;
      r_n         <= '0;
      r_u         <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rng       <= w_rng_d;
      r_dif       <= w_dif_d;
      r_cnt       <= w_cnt_d;
      r_eos       <= w_eos_d;
      r_sym       <= w_sym_d;
      r_sym_valid <= w_sym_valid_d;
      r_ret       <= w_ret_d;
      r_n         <= w_n_d;
      r_u         <= w_u_d;
    end
  end

  assign bus.in_ready   = w_fill_state && !r_eos;
  assign bus.req_ready  = (r_state == StIdle);
  assign bus.icdf_ready = (r_state == StSearch) && !w_is_bool;
  assign bus.sym        = r_sym;
  assign bus.sym_valid  = r_sym_valid;

  assign RNG_OUTPUT = r_rng;
  assign DIF_OUTPUT = r_dif;
  assign CNT_OUTPUT = r_cnt;

endmodule
